// File: rtl/div_period_meter.sv
// rtl/div_period_meter.sv - measures high/low time and period of a divided clock and tracks lock
module div_period_meter #(
    parameter int CNT_W    = 8,
    parameter int EXP_HALF = 8,
    parameter int LOCK_N   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    output logic             meas_valid,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W:0]   period,
    output logic             locked,
    output logic             err,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] EXP_VAL  = CNT_W'(EXP_HALF);
    localparam logic [3:0]       LOCK_VAL = 4'(LOCK_N);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS_HIGH,
        MEAS_LOW
    } state_t;

    state_t           state;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic             fall;
    logic             edge_det;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       match_cnt;
    logic             sat_seen;
    logic             sat_hit;
    logic             period_match;

    assign rise     = s2 & ~s3;
    assign fall     = ~s2 & s3;
    assign edge_det = rise | fall;

    // True in the cycle before cnt lands on all-ones; lets ovf/locked/err switch on that same edge.
    assign sat_hit = !edge_det && (cnt == CNT_MAX - 1'b1) && (state != IDLE);

    assign period_match = (high_cnt == EXP_VAL) && (cnt == EXP_VAL) && !sat_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= div_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (edge_det) begin
            cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            meas_valid <= 1'b0;
            high_cnt   <= '0;
            low_cnt    <= '0;
            period     <= '0;
            locked     <= 1'b0;
            err        <= 1'b0;
            ovf        <= 1'b0;
            match_cnt  <= '0;
            sat_seen   <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            err        <= 1'b0;

            if (edge_det) begin
                ovf <= 1'b0;
            end else if (sat_hit) begin
                ovf <= 1'b1;
            end

            // A stuck input drops lock immediately rather than waiting for the period to close.
            if (sat_hit) begin
                match_cnt <= '0;
                locked    <= 1'b0;
                err       <= locked;
                sat_seen  <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (fall) begin
                        state <= ARM;
                    end
                end
                ARM: begin
                    if (rise) begin
                        state    <= MEAS_HIGH;
                        sat_seen <= 1'b0;
                    end
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        high_cnt <= cnt;
                        state    <= MEAS_LOW;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        low_cnt    <= cnt;
                        period     <= {1'b0, high_cnt} + {1'b0, cnt};
                        meas_valid <= 1'b1;
                        sat_seen   <= 1'b0;
                        state      <= MEAS_HIGH;
                        if (period_match) begin
                            if (match_cnt != LOCK_VAL) begin
                                match_cnt <= match_cnt + 4'd1;
                            end
                            locked <= (match_cnt >= LOCK_VAL - 4'd1);
                        end else begin
                            match_cnt <= '0;
                            locked    <= 1'b0;
                            err       <= locked;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_period_meter.sv
// tb/tb_div_period_meter.sv - directed and random checks of div_period_meter against a segment-level model
module tb_div_period_meter;

    localparam int CNT_W    = 8;
    localparam int EXP_HALF = 8;
    localparam int LOCK_N   = 4;
    localparam int SAT      = 255;
    localparam int MAXN     = 2000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             div_in = 1'b0;
    logic             meas_valid;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] low_cnt;
    logic [CNT_W:0]   period;
    logic             locked;
    logic             err;
    logic             ovf;

    int total = 0;
    int bad   = 0;

    int seg_lvl[$];
    int seg_len[$];
    int lvl[MAXN];
    int e_mv[MAXN];
    int e_err[MAXN];
    int e_ovf[MAXN];
    int e_lock[MAXN];
    int e_high[MAXN];
    int e_low[MAXN];
    int e_per[MAXN];

    always #5 clk = ~clk;

    div_period_meter #(
        .CNT_W   (CNT_W),
        .EXP_HALF(EXP_HALF),
        .LOCK_N  (LOCK_N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .div_in    (div_in),
        .meas_valid(meas_valid),
        .high_cnt  (high_cnt),
        .low_cnt   (low_cnt),
        .period    (period),
        .locked    (locked),
        .err       (err),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, idx, obs, exp);
        end
    endtask

    task automatic add_seg(input int v, input int n);
        seg_lvl.push_back(v);
        seg_len.push_back(n);
    endtask

    function automatic void fill(input int which, input int from, input int n, input int val);
        for (int m = from; m < n; m++) begin
            case (which)
                0: e_high[m] = val;
                1: e_low[m]  = val;
                2: e_per[m]  = val;
                default: e_lock[m] = val;
            endcase
        end
    endfunction

    // Walks the waveform as a list of level runs; results of an edge sampled at index j appear at j+2.
    function automatic void build_model(input int n);
        int tr[$];
        int prev, st, run, lk, hi, j, len, s, m;
        bit rising, match;
        prev = 0; st = 0; run = 0; lk = 0; hi = 0;
        for (int k = 0; k < MAXN; k++) begin
            e_mv[k] = 0; e_err[k] = 0; e_ovf[k] = 0; e_lock[k] = 0;
            e_high[k] = 0; e_low[k] = 0; e_per[k] = 0;
        end
        for (int t = 0; t < n; t++) begin
            if (lvl[t] != prev) begin
                tr.push_back(t);
                prev = lvl[t];
            end
        end
        for (int i = 0; i <= tr.size(); i++) begin
            j = (i < tr.size()) ? tr[i] : n;
            if (i > 0 && st != 0 && j - tr[i-1] >= SAT) begin
                s = tr[i-1] + 256;
                for (m = s; m <= j + 1 && m < n; m++) e_ovf[m] = 1;
                if (s < n && lk != 0) e_err[s] = 1;
                lk = 0;
                run = 0;
                if (s < n) fill(3, s, n, 0);
            end
            if (i == tr.size()) break;
            len = (i > 0) ? j - tr[i-1] : j + 1;
            if (len > SAT) len = SAT;
            rising = (lvl[j] != 0);
            case (st)
                0: if (!rising) st = 1;
                1: if (rising) st = 2;
                2: if (!rising) begin
                    hi = len;
                    fill(0, j + 2, n, hi);
                    st = 3;
                end
                default: if (rising) begin
                    m = j + 2;
                    match = (hi == EXP_HALF) && (len == EXP_HALF);
                    if (m < n) begin
                        e_mv[m] = 1;
                        if (!match && lk != 0) e_err[m] = 1;
                    end
                    fill(1, m, n, len);
                    fill(2, m, n, hi + len);
                    run = match ? ((run < LOCK_N) ? run + 1 : run) : 0;
                    lk = (run >= LOCK_N) ? 1 : 0;
                    fill(3, m, n, lk);
                    st = 2;
                end
            endcase
        end
    endfunction

    task automatic check_sample(input int m);
        chk("meas_valid", m, meas_valid, e_mv[m]);
        chk("err", m, err, e_err[m]);
        chk("ovf", m, ovf, e_ovf[m]);
        chk("locked", m, locked, e_lock[m]);
        chk("high_cnt", m, high_cnt, e_high[m]);
        chk("low_cnt", m, low_cnt, e_low[m]);
        chk("period", m, period, e_per[m]);
    endtask

    // Asserts reset off-edge, checks immediate clearing, then plays the queued segments.
    task automatic run_phase(input int hold_lvl, input int hold_cycles);
        int n;
        n = 0;
        foreach (seg_lvl[i]) begin
            for (int k = 0; k < seg_len[i]; k++) begin
                lvl[n] = seg_lvl[i];
                n++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            lvl[n] = lvl[n-1];
            n++;
        end
        seg_lvl.delete();
        seg_len.delete();
        build_model(n);

        @(negedge clk);
        #3;
        rst = 1'b1;
        div_in = hold_lvl[0];
        #1;
        chk("rst_meas_valid", 0, meas_valid, 0);
        chk("rst_locked", 0, locked, 0);
        chk("rst_err", 0, err, 0);
        chk("rst_ovf", 0, ovf, 0);
        chk("rst_high_cnt", 0, high_cnt, 0);
        chk("rst_low_cnt", 0, low_cnt, 0);
        chk("rst_period", 0, period, 0);
        repeat (hold_cycles) @(negedge clk);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            if (t > 0) check_sample(t - 1);
            rst = 1'b0;
            div_in = lvl[t][0];
        end
        @(negedge clk);
        check_sample(n - 1);
    endtask

    task automatic add_good(input int periods);
        for (int k = 0; k < periods; k++) begin
            add_seg(1, EXP_HALF);
            add_seg(0, EXP_HALF);
        end
    endtask

    initial begin
        // reset held with the input high, then left high: nothing may be reported
        add_seg(1, 40);
        run_phase(1, 20);

        // lock, bad period, relock, stuck low, glitch, relock, stop mid-high
        add_seg(1, EXP_HALF);
        add_seg(0, EXP_HALF);
        add_good(6);
        add_seg(1, 6);
        add_seg(0, 10);
        add_good(5);
        add_seg(1, EXP_HALF);
        add_seg(0, 300);
        add_good(3);
        add_seg(1, EXP_HALF);
        add_seg(0, 3);
        add_seg(1, 1);
        add_seg(0, 4);
        add_good(5);
        add_seg(1, 4);
        run_phase(0, 2);
        chk("locked_before_rst", 0, locked, 1);

        // mid-period reset while locked; needs a fresh fall/rise/fall/rise
        add_seg(1, 5);
        add_seg(0, EXP_HALF);
        add_good(3);
        add_seg(1, EXP_HALF);
        run_phase(1, 1);

        // random half-periods, mostly nominal, with one stuck stretch
        for (int k = 0; k < 60; k++) begin
            if (k == 31) add_seg(0, 260);
            else add_seg((k % 2 == 0) ? 1 : 0,
                         ($urandom_range(0, 9) < 6) ? EXP_HALF : int'($urandom_range(1, 14)));
        end
        run_phase(0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_period_meter.md
# div_period_meter

Receive-side checker for the divided clocks our divider blocks generate. It samples a slow square wave (for example a divide-by-16 output) in the `clk` domain and measures its high time, low time and period in `clk` cycles. It raises `locked` once the waveform repeatedly matches the expected half-period, and flags loss of lock. It sits downstream of any divider output as a self-check and monitoring block.

## Interface
- `CNT_W`, 8: width of the high/low counters; counts saturate at 2^CNT_W−1.
- `EXP_HALF`, 8: expected high time and low time, in `clk` cycles. Legal range 1 to 2^CNT_W−2.
- `LOCK_N`, 4: consecutive matching periods required to assert `locked`. Legal range 1 to 15.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `div_in`  in  1  square wave under test; treated as asynchronous.
- `meas_valid`  out  1  one-cycle pulse when a full period has been measured.
- `high_cnt`  out  CNT_W  last measured high time; updated on each falling edge.
- `low_cnt`  out  CNT_W  last measured low time; updated together with `meas_valid`.
- `period`  out  CNT_W+1  `high_cnt + low_cnt`, full width with no truncation; updated with `meas_valid`.
- `locked`  out  1  waveform matches `EXP_HALF`/`EXP_HALF` for `LOCK_N` consecutive periods.
- `err`  out  1  one-cycle pulse when lock is lost.
- `ovf`  out  1  level; high while the level counter is saturated.

## Operation
- Input path: a 2-flop synchronizer (s1, s2), then an edge register s3. All three reset to 0.
  - `rise = s2 & ~s3`
  - `fall = ~s2 & s3`
- Level counter `cnt`:
  - Loads 1 on any `rise` or `fall`.
  - Otherwise increments, saturating at all-ones.
  - At an edge, `cnt` equals the number of cycles the previous level lasted.
- State machine, reset to IDLE:
  - IDLE: discard everything until the first `fall`, then go to ARM. This avoids a false rise when `div_in` is high at reset.
  - ARM: on `rise`, go to MEAS_HIGH. Nothing is reported.
  - MEAS_HIGH: on `fall`, load `high_cnt <= cnt` and go to MEAS_LOW.
  - MEAS_LOW: on `rise`, do all of the following, then return to MEAS_HIGH:
    - load `low_cnt <= cnt` and `period <= high_cnt + cnt`;
    - pulse `meas_valid`;
    - evaluate the match.
- Match rule: a period matches when the high time equals `EXP_HALF`, the low time equals `EXP_HALF`, and no saturation occurred during that period.
  - Match: the match counter increments, saturating at `LOCK_N`. `locked` sets when the counter reaches `LOCK_N`.
  - Mismatch: the match counter clears and `locked` clears. `err` pulses if `locked` was 1.
- Saturation (stuck input), in any non-IDLE state:
  - `ovf` goes high in the cycle `cnt` reaches all-ones and stays high until the next edge.
  - In the same cycle, `locked` and the match counter clear, and `err` pulses once if `locked` was 1.
  - The state machine keeps its state. The period containing the saturation is reported at its closing `rise` as a mismatch.
- Glitches are not filtered: a 1-cycle pulse is measured as a 1-cycle level.

## Timing
- Reset values:
  - `meas_valid`, `err`, `ovf`, `locked` = 0.
  - `high_cnt`, `low_cnt`, `period` = 0.
  - State = IDLE; `cnt` = 0; match counter = 0.
- Edge latency: a `div_in` transition first sampled at clk edge k produces `rise`/`fall` in the cycle after edge k+1. Registered outputs update at edge k+2.
- `meas_valid`, `low_cnt`, `period` and the `locked`/`err` update are all registered on the same edge (k+2).
- `high_cnt` updates at k+2 relative to the falling transition.
- Ideal divide-by-16 from the same clock: `meas_valid` pulses every 16 cycles. `locked` rises with the `LOCK_N`-th `meas_valid` after arming.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous). After reset release, the block re-enters IDLE and needs a fresh fall→rise before the first measurement.

## Test plan
- Reset with `div_in`=1 held for 20 cycles, then released → no `meas_valid`; `locked`=0; all outputs 0; state stays IDLE/ARM.
- Ideal 8-high/8-low wave, defaults → each `meas_valid` gives `high_cnt`=8, `low_cnt`=8, `period`=16. `locked` rises on the 4th `meas_valid`; no `err`.
- After lock, one period of 6 high/10 low → that `meas_valid` shows 6/10/16. `err` pulses 1 cycle with it; `locked`=0. Lock is regained after 4 further good periods.
- After lock, `div_in` held low for 300 cycles → `ovf` rises when `cnt`=255; `locked` drops and `err` pulses once at that cycle. At the next rise, `low_cnt`=255 and there is no relock. `ovf` clears at the edge.
- A single 1-cycle high glitch inside a low phase → two short measurements (e.g. `high_cnt`=1); match counter clears; `locked` is not set by these.
- `rst` pulsed for 1 cycle while locked mid-period → all outputs 0 immediately. After release, the first `meas_valid` appears only after a full fall→rise→fall→rise sequence.
